invader_missiles: RTL and testbench

Parametrised invader-missile engine for NUM_MISSILES independent missiles. It launches each missile from a randomly chosen live invader column. It moves active missiles down once per frame and retires them at the screen bottom or on a player hit, then holds each slot in a per-slot reload cooldown. It sits between the invader formation logic, which supplies the formation origin and column-alive mask, and the collision/renderer blocks, which consume the missile positions and activity flags.

---
 rtl/invader_missiles.sv | 210 +++++++++++++++++++++
 tb/tb_invader_missiles.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/invader_missiles.sv
// -----------------------------------------------------------------------------
// invader_missiles
// Invader missile engine for NUM_MISSILES independent slots. A spawn FSM picks
// a pseudo-random live invader column and launches one missile at a time into
// the lowest free slot. Active missiles fall MISSILE_STEP px per frame and are
// retired at the bottom of the screen or on a player hit, after which the slot
// waits RELOAD_FRAMES frames before it can be reused.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   frame         one-cycle pulse per video frame
//   enable        permits new launches (active missiles keep moving regardless)
//   invaders_x/y  formation origin
//   column_alive  bit c set when formation column c still has a live invader
//   hit           per-slot player-collision flags
//   m_x, m_y      packed missile positions, slot i at [10i+9:10i]
//   m_active      slot i currently on screen
// -----------------------------------------------------------------------------
module invader_missiles #(
    parameter int          NUM_MISSILES  = 3,
    parameter int          INVADERS_H    = 11,
    parameter int          INVADERS_V    = 5,
    parameter int          SPRITE_W      = 24,
    parameter int          SPRITE_H      = 16,
    parameter int          OFFSET_H      = 32,
    parameter int          PROJ_H        = 8,
    parameter int          RES_V         = 480,
    parameter int          MISSILE_STEP  = 4,
    parameter int          RELOAD_FRAMES = 30,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      enable,
    input  logic [9:0]                invaders_x,
    input  logic [9:0]                invaders_y,
    input  logic [INVADERS_H-1:0]     column_alive,
    input  logic [NUM_MISSILES-1:0]   hit,
    output logic [10*NUM_MISSILES-1:0] m_x,
    output logic [10*NUM_MISSILES-1:0] m_y,
    output logic [NUM_MISSILES-1:0]   m_active
);

    localparam int SLOT_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
    localparam int COL_W  = (INVADERS_H > 1) ? $clog2(INVADERS_H) : 1;

    localparam logic [7:0]       H8         = 8'(INVADERS_H);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(INVADERS_H - 1);
    localparam logic [9:0]       X_CENTER   = 10'(SPRITE_W / 2);
    localparam logic [9:0]       PITCH      = 10'(OFFSET_H);
    localparam logic [9:0]       Y_BELOW    = 10'(INVADERS_V * SPRITE_H);
    localparam logic [9:0]       STEP       = 10'(MISSILE_STEP);
    localparam logic [9:0]       Y_LIMIT    = 10'(RES_V - PROJ_H);
    localparam logic [7:0]       RELOAD     = 8'(RELOAD_FRAMES);

    typedef enum logic [1:0] {
        SP_IDLE   = 2'd0,
        SP_SCAN   = 2'd1,
        SP_LAUNCH = 2'd2
    } sp_state_t;

    sp_state_t           state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [9:0]          mx_q [NUM_MISSILES];
    logic [9:0]          mx_d [NUM_MISSILES];
    logic [9:0]          my_q [NUM_MISSILES];
    logic [9:0]          my_d [NUM_MISSILES];
    logic [7:0]          cool_q [NUM_MISSILES];
    logic [7:0]          cool_d [NUM_MISSILES];
    logic [NUM_MISSILES-1:0] active_q, active_d;

    logic [NUM_MISSILES-1:0] eligible_s;
    logic [SLOT_W-1:0]       first_slot_s;
    logic [7:0]              col_mod_s;
    logic [9:0]              launch_x_s;
    logic [9:0]              launch_y_s;

    // Slot eligibility and lowest-index free slot selection.
    always_comb begin
        first_slot_s = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            eligible_s[i] = !active_q[i] && (cool_q[i] == 8'd0);
        end
        // Scanning downward leaves the lowest eligible index as the winner.
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                first_slot_s = SLOT_W'(i);
            end else begin
                first_slot_s = first_slot_s;
            end
        end
    end

    // Launch position and random start column (all 10-bit truncating).
    always_comb begin
        col_mod_s  = lfsr_q[7:0] % H8;
        launch_x_s = invaders_x + (10'(col_q) * PITCH) + X_CENTER;
        launch_y_s = invaders_y + Y_BELOW;
    end

    // Next-state logic: LFSR, spawn FSM and per-slot missile updates.
    always_comb begin
        // Galois LFSR, taps 16,14,13,11, shifting right.
        if (lfsr_q[0]) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ 16'hB400;
        end else begin
            lfsr_d = {1'b0, lfsr_q[15:1]};
        end

        state_d = state_q;
        slot_d  = slot_q;
        col_d   = col_q;

        case (state_q)
            SP_IDLE: begin
                if (enable && (|eligible_s) && (|column_alive)) begin
                    slot_d  = first_slot_s;
                    col_d   = COL_W'(col_mod_s);
                    state_d = SP_SCAN;
                end else begin
                    state_d = SP_IDLE;
                end
            end
            SP_SCAN: begin
                // Abort has precedence so a dropped enable never launches.
                if (!enable || (column_alive == '0)) begin
                    state_d = SP_IDLE;
                end else if (column_alive[col_q]) begin
                    state_d = SP_LAUNCH;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            SP_LAUNCH: begin
                state_d = SP_IDLE;
            end
            default: begin
                state_d = SP_IDLE;
            end
        endcase

        active_d = active_q;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            mx_d[i]   = mx_q[i];
            my_d[i]   = my_q[i];
            cool_d[i] = cool_q[i];
            if ((state_q == SP_LAUNCH) && (slot_q == SLOT_W'(i)) && !active_q[i]) begin
                // A fresh launch does not move even on a frame cycle.
                active_d[i] = 1'b1;
                mx_d[i]     = launch_x_s;
                my_d[i]     = launch_y_s;
            end else if (active_q[i] && hit[i]) begin
                active_d[i] = 1'b0;
                cool_d[i]   = RELOAD;
            end else if (active_q[i] && frame) begin
                if ((my_q[i] + STEP) >= Y_LIMIT) begin
                    active_d[i] = 1'b0;
                    cool_d[i]   = RELOAD;
                end else begin
                    my_d[i] = my_q[i] + STEP;
                end
            end else if (!active_q[i] && frame && (cool_q[i] != 8'd0)) begin
                cool_d[i] = cool_q[i] - 8'd1;
            end else begin
                cool_d[i] = cool_q[i];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SP_IDLE;
            slot_q   <= '0;
            col_q    <= '0;
            lfsr_q   <= SEED;
            active_q <= '0;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                mx_q[i]   <= 10'd0;
                my_q[i]   <= 10'd0;
                cool_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            col_q    <= col_d;
            lfsr_q   <= lfsr_d;
            active_q <= active_d;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                mx_q[i]   <= mx_d[i];
                my_q[i]   <= my_d[i];
                cool_q[i] <= cool_d[i];
            end
        end
    end

    assign m_active = active_q;

    for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_pack
        assign m_x[10*g +: 10] = mx_q[g];
        assign m_y[10*g +: 10] = my_q[g];
    end

endmodule

// File: tb/tb_invader_missiles.sv
module tb_invader_missiles;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  invaders_x = 10'd0;
    logic [9:0]  invaders_y = 10'd0;
    logic [10:0] column_alive = 11'd0;
    logic [2:0]  hit = 3'd0;
    logic [29:0] m_x;
    logic [29:0] m_y;
    logic [2:0]  m_active;

    int n_checks = 0;
    int n_pass   = 0;

    invader_missiles dut (
        .clk          (clk),
        .rst          (rst),
        .frame        (frame),
        .enable       (enable),
        .invaders_x   (invaders_x),
        .invaders_y   (invaders_y),
        .column_alive (column_alive),
        .hit          (hit),
        .m_x          (m_x),
        .m_y          (m_y),
        .m_active     (m_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  inv_x;
        logic [9:0]  inv_y;
        logic [10:0] alive;
        logic [9:0]  exp_x;
        logic [9:0]  exp_y;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        frame  = 1'b0;
        hit    = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits up to budget negedges for slot idx to become active.
    task automatic wait_active(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_active[idx]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_frame(input logic [2:0] h);
        @(negedge clk);
        frame = 1'b1;
        hit   = h;
        @(negedge clk);
        frame = 1'b0;
        hit   = 3'd0;
    endtask

    function automatic logic [9:0] ys(input int i);
        return m_y[10*i +: 10];
    endfunction

    function automatic logic [9:0] xs(input int i);
        return m_x[10*i +: 10];
    endfunction

    initial begin
        bit ok;
        bit seen;

        // inv_x, inv_y, single live column, expected spawn x, y
        vecs[0] = '{10'd40,   10'd60,  11'b000_1000_0000, 10'd276,  10'd140};
        vecs[1] = '{10'd0,    10'd0,   11'b000_0000_0001, 10'd12,   10'd80};
        vecs[2] = '{10'd100,  10'd20,  11'b100_0000_0000, 10'd432,  10'd100};
        vecs[3] = '{10'd1000, 10'd300, 11'b000_0010_0000, 10'd148,  10'd380};

        do_reset();
        check("reset_active", 32'(m_active), 32'd0);
        check("reset_x", 32'(m_x), 32'd0);
        check("reset_y", 32'(m_y), 32'd0);

        // Launch position table, one reset per entry
        for (int v = 0; v < 4; v++) begin
            do_reset();
            invaders_x   = vecs[v].inv_x;
            invaders_y   = vecs[v].inv_y;
            column_alive = vecs[v].alive;
            enable       = 1'b1;
            wait_active(0, 14, ok);
            check($sformatf("vec%0d_launch", v), 32'(ok), 32'd1);
            check($sformatf("vec%0d_x", v), 32'(xs(0)), 32'(vecs[v].exp_x));
            check($sformatf("vec%0d_y", v), 32'(ys(0)), 32'(vecs[v].exp_y));
        end

        // All three slots fill at the same spawn point
        do_reset();
        invaders_x   = 10'd40;
        invaders_y   = 10'd60;
        column_alive = 11'b000_1000_0000;
        enable       = 1'b1;
        wait_active(0, 14, ok);
        check("single_launch_latency", 32'(ok), 32'd1);
        wait_active(2, 40, ok);
        check("three_active", 32'(m_active), 32'd7);
        for (int i = 1; i < 3; i++) begin
            check($sformatf("slot%0d_x", i), 32'(xs(i)), 32'd276);
            check($sformatf("slot%0d_y", i), 32'(ys(i)), 32'd140);
        end

        // Missiles keep falling with launches disabled
        enable = 1'b0;
        for (int f = 0; f < 10; f++) pulse_frame(3'd0);
        check("fall10_y0", 32'(ys(0)), 32'd180);

        // Hit beats movement on the same cycle
        pulse_frame(3'b010);
        check("hit_active", 32'(m_active), 32'b101);
        check("hit_y1_held", 32'(ys(1)), 32'd180);
        check("hit_y0_moved", 32'(ys(0)), 32'd184);
        check("hit_y2_moved", 32'(ys(2)), 32'd184);

        // Fall to the bottom: 82 frames total reach 468, the 83rd retires
        for (int f = 0; f < 71; f++) pulse_frame(3'd0);
        check("bottom_y0", 32'(ys(0)), 32'd468);
        check("bottom_active0", 32'(m_active[0]), 32'd1);
        pulse_frame(3'd0);
        check("retire_active", 32'(m_active), 32'd0);
        check("retire_y0_held", 32'(ys(0)), 32'd468);

        // Slot 1 cooled down long ago and relaunches first
        enable = 1'b1;
        wait_active(1, 14, ok);
        check("slot1_relaunch", 32'(ok), 32'd1);
        check("slot1_relaunch_x", 32'(xs(1)), 32'd276);

        // Slot 0 must wait exactly 30 frames of cooldown
        for (int f = 0; f < 29; f++) pulse_frame(3'd0);
        repeat (20) @(negedge clk);
        check("cooldown_hold", 32'({m_active[2], m_active[0]}), 32'd0);
        pulse_frame(3'd0);
        wait_active(0, 14, ok);
        check("cooldown_relaunch", 32'(ok), 32'd1);
        check("cooldown_relaunch_y", 32'(ys(0)), 32'd140);
        wait_active(2, 30, ok);
        check("all_active_again", 32'(m_active), 32'd7);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_active", 32'(m_active), 32'd0);
        check("async_x", 32'(m_x), 32'd0);
        check("async_y", 32'(m_y), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Dead formation: nothing launches
        column_alive = 11'd0;
        enable       = 1'b1;
        seen         = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (m_active != 3'd0) seen = 1'b1;
        end
        check("dead_no_launch", 32'(seen), 32'd0);
        column_alive = 11'b000_1000_0000;
        wait_active(0, 14, ok);
        check("dead_then_alive", 32'(ok), 32'd1);

        // Abort: enable high for exactly one cycle, dropped while scanning
        do_reset();
        invaders_x   = 10'd40;
        invaders_y   = 10'd60;
        column_alive = 11'b100_0000_0000;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        seen   = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_active != 3'd0) seen = 1'b1;
        end
        check("abort_no_launch", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
